flit_reassembly: RTL and testbench
==================================

FLIT_REASSEMBLY -- requirements
Module: flit_reassembly

Interface
REQ-001 SHALL have parameter NUM_MSHR, default 4, number of reassembly slots, one per mshr_id value.
REQ-002 SHALL have parameter MAX_FLITS, default 4, maximum flits per packet.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ej_flit, input, flit_int_t, ejected flit from router; sampled only when ej_flit.vld=1.
REQ-006 SHALL have port pkt_vld, output, 1, reassembled packet available.
REQ-007 SHALL have port pkt_rdy, input, 1, consumer accepts packet.
REQ-008 SHALL have port pkt_mshr_id, output, mshr_id width, slot of presented packet.
REQ-009 SHALL have port pkt_requester_id, output, requester_id width, requester of presented packet.
REQ-010 SHALL have port pkt_size, output, pkt_size width, flit count of presented packet.
REQ-011 SHALL have port pkt_payload, output, MAX_FLITS*payload width, flit k payload at slice k.
REQ-012 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-013 SHALL always accept ej_flit (no backpressure); one flit per cycle maximum.
REQ-014 SHALL index slot by ej_flit.mshr_id; fields deflect, golden, silver, ppv, dst_x, dst_y ignored.
REQ-015 SHALL keep per-slot state IDLE/COLLECT/DONE, a MAX_FLITS-bit received mask, requester_id, pkt_size and payload array.
REQ-016 SHALL, on valid flit to IDLE slot, latch requester_id/pkt_size, store payload at flit_id, set mask bit; go DONE if pkt_size=1, else COLLECT.
REQ-017 SHALL, on valid flit to COLLECT slot, store payload at flit_id, set mask bit; go DONE when mask popcount reaches pkt_size (out-of-order flit_id accepted).
REQ-018 SHALL select among DONE slots with round-robin priority starting after last-granted slot; slot 0 first after reset.
REQ-019 SHALL register output: load selected DONE slot into output stage when stage empty or handshaking; minimum latency last-flit edge to pkt_vld high = 2 cycles.
REQ-020 SHALL hold all pkt_* outputs stable while pkt_vld=1 and pkt_rdy=0.
REQ-021 SHALL, on pkt_vld&pkt_rdy, return granted slot to IDLE with mask cleared at same edge; back-to-back packets SHALL sustain one per cycle.
REQ-022 SHALL mark a slot as loaded-into-output so it is not selected twice; slot becomes IDLE only at handshake.
REQ-023 SHALL allow a flit to a slot freed at edge E to be accepted at edge E+1; flit and handshake at same edge to same slot is error case (REQ-030).

Reset
REQ-024 SHALL, on reset=1 at rising edge, set all slots IDLE, masks 0, pkt_vld=0, err=0, round-robin pointer to 0.
REQ-025 SHALL drive pkt_mshr_id, pkt_requester_id, pkt_size, pkt_payload to 0 after reset.
REQ-026 SHALL discard partial packets and any held output when reset is asserted mid-operation; ej_flit ignored during reset cycle.

Configuration
REQ-027 SHALL support macro REASM_ERR_CHK_EN.
REQ-028 SHALL, with REASM_ERR_CHK_EN defined, set err (sticky until reset) and drop the flit on: duplicate flit_id in COLLECT slot, flit to DONE slot, flit_id>=pkt_size, pkt_size=0 or >MAX_FLITS, pkt_size mismatch with latched value.
REQ-029 SHALL, without REASM_ERR_CHK_EN, tie err to 0 and let such flits overwrite payload without state change beyond REQ-016/017.
REQ-030 SHALL treat flit to slot being handshaken at same edge per REQ-028/029 (DONE-slot case).

Structure
REQ-031 SHALL take flit_int_t and field widths from the shared flit package; NUM_MSHR/MAX_FLITS defaults and slot-state enum SHALL live in the shared global package.
REQ-032 SHALL instantiate one sub-module reasm_rr_arbiter (NUM_MSHR-wide request/grant, pointer update on grant).

Verification
REQ-033 Single flit mshr 2, size 1, payload 0xA5, pkt_rdy=1 -> pkt_vld 2 cycles later, mshr 2, slice0 0xA5, slot 2 IDLE next cycle.
REQ-034 Size-4 packet mshr 1, flit_ids 3,0,2,1 consecutive -> one pkt_vld, slices ordered 0..3, no earlier pkt_vld.
REQ-035 Interleave mshr 0 and 3 size-2 packets, pkt_rdy=0 for 5 cycles -> pkt_vld held with mshr 0 stable; raise pkt_rdy -> mshr 0 then mshr 3 on consecutive cycles.
REQ-036 All 4 slots DONE simultaneously, pkt_rdy=1 -> grants 0,1,2,3 over 4 consecutive cycles.
REQ-037 With REASM_ERR_CHK_EN: duplicate flit_id 1 to COLLECT slot -> err=1 until reset, packet completes from remaining flits; without macro err stays 0.
REQ-038 Reset asserted after 2 of 4 flits -> pkt_vld never asserts; fresh packet to same mshr reassembles correctly.

Source files
------------

// File: rtl/flit_reassembly_pkg.sv
// flit_reassembly_pkg: flit format, field widths, reassembly defaults and slot-state encoding
package flit_reassembly_pkg;
  localparam int NUM_MSHR_DEF = 4;
  localparam int MAX_FLITS_DEF = 4;
  localparam int MSHR_W = 2;
  localparam int REQ_W = 4;
  localparam int SIZE_W = 3;
  localparam int FID_W = 2;
  localparam int PAYLOAD_W = 8;
  localparam int PPV_W = 4;
  localparam int COORD_W = 2;
  typedef struct packed {
    logic vld;
    logic deflect;
    logic golden;
    logic silver;
    logic [PPV_W-1:0] ppv;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [MSHR_W-1:0] mshr_id;
    logic [REQ_W-1:0] requester_id;
    logic [SIZE_W-1:0] pkt_size;
    logic [FID_W-1:0] flit_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_int_t;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_COLLECT, SLOT_DONE} slot_state_e;
endpackage

// File: rtl/flit_reassembly_if.sv
// flit_reassembly_if: ejected-flit input plus reassembled-packet valid/ready output bus
interface flit_reassembly_if import flit_reassembly_pkg::*; #(
  parameter int MAX_FLITS = MAX_FLITS_DEF
);
  flit_int_t ej_flit;
  logic pkt_vld;
  logic pkt_rdy;
  logic [MSHR_W-1:0] pkt_mshr_id;
  logic [REQ_W-1:0] pkt_requester_id;
  logic [SIZE_W-1:0] pkt_size;
  logic [MAX_FLITS*PAYLOAD_W-1:0] pkt_payload;
  logic err;
  modport master (
    input ej_flit, pkt_rdy,
    output pkt_vld, pkt_mshr_id, pkt_requester_id, pkt_size, pkt_payload, err
  );
  modport slave (
    output ej_flit, pkt_rdy,
    input pkt_vld, pkt_mshr_id, pkt_requester_id, pkt_size, pkt_payload, err
  );
endinterface

// File: rtl/reasm_rr_arbiter.sv
// reasm_rr_arbiter: round-robin grant over N requesters, search starts just after the last taken grant
module reasm_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input logic clk,
  input logic reset,
  input logic [N-1:0] req,
  input logic advance,
  output logic [N-1:0] gnt,
  output logic [IW-1:0] gnt_idx,
  output logic gnt_vld
);
  logic [IW-1:0] ptr, cand;
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = '0;
    gnt[gnt_idx] = gnt_vld;
  end
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (advance && gnt_vld) ptr <= IW'((int'(gnt_idx) + 1) % N);
endmodule

// File: rtl/flit_reassembly.sv
// flit_reassembly: per-MSHR reassembly of ejected flits with a registered round-robin packet output stage.
// Define REASM_ERR_CHK_EN to drop malformed flits and raise the sticky err flag.
module flit_reassembly import flit_reassembly_pkg::*; #(
  parameter int NUM_MSHR = NUM_MSHR_DEF,
  parameter int MAX_FLITS = MAX_FLITS_DEF
) (
  input logic clk,
  input logic reset,
  flit_reassembly_if.master bus
);
  localparam int IW = $clog2(NUM_MSHR);
  slot_state_e state_q [NUM_MSHR], state_n [NUM_MSHR];
  logic [MAX_FLITS-1:0] mask_q [NUM_MSHR], mask_n [NUM_MSHR];
  logic [REQ_W-1:0] rid_q [NUM_MSHR], rid_n [NUM_MSHR];
  logic [SIZE_W-1:0] size_q [NUM_MSHR], size_n [NUM_MSHR];
  logic [PAYLOAD_W-1:0] data_q [NUM_MSHR][MAX_FLITS], data_n [NUM_MSHR][MAX_FLITS];
  logic [NUM_MSHR-1:0] loaded_q, loaded_n, done_q, is_done, req, gnt;
  logic [IW-1:0] fs, gnt_idx, out_idx;
  logic [FID_W-1:0] fid;
  logic [MAX_FLITS-1:0] new_mask;
  logic [SIZE_W-1:0] cur_size, out_size;
  logic [REQ_W-1:0] out_rid;
  logic [MAX_FLITS*PAYLOAD_W-1:0] sel_payload, out_payload;
  logic gnt_vld, out_vld, hs, load, bad, unused_fields;
  assign fs = IW'(bus.ej_flit.mshr_id);
  assign fid = bus.ej_flit.flit_id;
  assign hs = out_vld && bus.pkt_rdy;
  assign load = gnt_vld && (!out_vld || bus.pkt_rdy);
  assign unused_fields = ^{bus.ej_flit.deflect, bus.ej_flit.golden, bus.ej_flit.silver,
                           bus.ej_flit.ppv, bus.ej_flit.dst_x, bus.ej_flit.dst_y};
  // done_q delays arbitration eligibility one cycle after a slot completes
  always_comb begin
    is_done = '0;
    for (int i = 0; i < NUM_MSHR; i++) is_done[i] = state_q[i] == SLOT_DONE;
    req = is_done & done_q & ~loaded_q;
  end
  reasm_rr_arbiter #(.N(NUM_MSHR)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .advance(load),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );
  always_comb begin
    bad = 1'b0;
`ifdef REASM_ERR_CHK_EN
    bad = state_q[fs] == SLOT_DONE || bus.ej_flit.pkt_size == '0 ||
          bus.ej_flit.pkt_size > SIZE_W'(MAX_FLITS) || SIZE_W'(fid) >= bus.ej_flit.pkt_size ||
          (state_q[fs] == SLOT_COLLECT && (mask_q[fs][fid] || bus.ej_flit.pkt_size != size_q[fs]));
`endif
  end
  // handshake is applied last so a slot leaving the output always returns to IDLE
  always_comb begin
    state_n = state_q;
    mask_n = mask_q;
    rid_n = rid_q;
    size_n = size_q;
    data_n = data_q;
    loaded_n = loaded_q | (load ? gnt : '0);
    cur_size = state_q[fs] == SLOT_IDLE ? bus.ej_flit.pkt_size : size_q[fs];
    new_mask = mask_q[fs] | (MAX_FLITS'(1) << fid);
    if (bus.ej_flit.vld && !bad) begin
      data_n[fs][fid] = bus.ej_flit.payload;
      mask_n[fs] = new_mask;
      if (state_q[fs] == SLOT_IDLE) begin
        rid_n[fs] = bus.ej_flit.requester_id;
        size_n[fs] = bus.ej_flit.pkt_size;
      end
      if (state_q[fs] != SLOT_DONE)
        state_n[fs] = SIZE_W'($countones(new_mask)) == cur_size ? SLOT_DONE : SLOT_COLLECT;
    end
    if (hs) begin
      state_n[out_idx] = SLOT_IDLE;
      mask_n[out_idx] = '0;
      loaded_n[out_idx] = 1'b0;
    end
  end
  always_comb begin
    sel_payload = '0;
    for (int k = 0; k < MAX_FLITS; k++) sel_payload[k*PAYLOAD_W +: PAYLOAD_W] = data_q[gnt_idx][k];
  end
  always_ff @(posedge clk) begin
    rid_q <= rid_n;
    size_q <= size_n;
    data_q <= data_n;
    if (reset) begin
      state_q <= '{default: SLOT_IDLE};
      mask_q <= '{default: '0};
      loaded_q <= '0;
      done_q <= '0;
      out_vld <= 1'b0;
      out_idx <= '0;
      out_rid <= '0;
      out_size <= '0;
      out_payload <= '0;
    end else begin
      state_q <= state_n;
      mask_q <= mask_n;
      loaded_q <= loaded_n;
      done_q <= is_done;
      if (load) begin
        out_vld <= 1'b1;
        out_idx <= gnt_idx;
        out_rid <= rid_q[gnt_idx];
        out_size <= size_q[gnt_idx];
        out_payload <= sel_payload;
      end else if (hs) out_vld <= 1'b0;
    end
  end
`ifdef REASM_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk) err_q <= reset ? 1'b0 : err_q | (bus.ej_flit.vld & bad);
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.pkt_vld = out_vld;
  assign bus.pkt_mshr_id = MSHR_W'(out_idx);
  assign bus.pkt_requester_id = out_rid;
  assign bus.pkt_size = out_size;
  assign bus.pkt_payload = out_payload;
endmodule

// File: tb/tb_flit_reassembly.sv
// tb_flit_reassembly: directed scenarios plus randomized traffic checked against a per-slot packet model
module tb_flit_reassembly;
  import flit_reassembly_pkg::*;
  localparam int NPKT = 60;
  logic clk = 1'b0;
  logic reset;
  int n_chk, n_fail;
  always #5 clk = ~clk;
  flit_reassembly_if bus();
  flit_reassembly dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic flit_int_t mk(input int m, input int r, input int s, input int f, input int p);
    flit_int_t x;
    x.vld = 1'b1;
    x.deflect = 1'($urandom);
    x.golden = 1'($urandom);
    x.silver = 1'($urandom);
    x.ppv = PPV_W'($urandom);
    x.dst_x = COORD_W'($urandom);
    x.dst_y = COORD_W'($urandom);
    x.mshr_id = MSHR_W'(m);
    x.requester_id = REQ_W'(r);
    x.pkt_size = SIZE_W'(s);
    x.flit_id = FID_W'(f);
    x.payload = PAYLOAD_W'(p);
    return x;
  endfunction
  task automatic send(input int m, input int r, input int s, input int f, input int p);
    bus.ej_flit = mk(m, r, s, f, p);
    tick();
    bus.ej_flit = '0;
  endtask
  task automatic wait_vld(input string tag, input int lim);
    int c;
    c = 0;
    while (!bus.pkt_vld && c < lim) begin
      tick();
      c++;
    end
    check(tag, bus.pkt_vld, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    int ord4[4];
    int busy[4], sz[4], rid[4], nxt[4], ord[4][4];
    logic [7:0] dat[4][4];
    logic [31:0] exp_pl, msk;
    logic [63:0] cur, hold_val;
    logic hold_v, hs;
    int started, delivered, cyc, m, j, s0, chosen, b, t, free_m;
    logic exp_err;
`ifdef REASM_ERR_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.ej_flit = '0;
    bus.pkt_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_vld", bus.pkt_vld, 0);
    check("rst_err", bus.err, 0);
    check("rst_mshr", bus.pkt_mshr_id, 0);
    check("rst_rid", bus.pkt_requester_id, 0);
    check("rst_size", bus.pkt_size, 0);
    check("rst_payload", bus.pkt_payload, 0);
    // single flit: valid two edges after the flit edge, slot reusable right after handshake
    bus.pkt_rdy = 1'b1;
    send(2, 5, 1, 0, 'hA5);
    check("t033_e1", bus.pkt_vld, 0);
    tick();
    check("t033_e2", bus.pkt_vld, 0);
    tick();
    check("t033_vld", bus.pkt_vld, 1);
    check("t033_mshr", bus.pkt_mshr_id, 2);
    check("t033_p0", bus.pkt_payload[7:0], 'hA5);
    check("t033_size", bus.pkt_size, 1);
    check("t033_rid", bus.pkt_requester_id, 5);
    tick();
    check("t033_hs", bus.pkt_vld, 0);
    send(2, 6, 1, 0, 'h5A);
    tick();
    tick();
    check("t033_reuse_vld", bus.pkt_vld, 1);
    check("t033_reuse_pl", {bus.pkt_requester_id, bus.pkt_payload[7:0]}, {4'd6, 8'h5A});
    tick();
    check("t033_reuse_hs", bus.pkt_vld, 0);
    // out-of-order flits of a 4-flit packet
    ord4 = '{3, 0, 2, 1};
    for (int i = 0; i < 4; i++) begin
      send(1, 9, 4, ord4[i], 'h10 + ord4[i]);
      check("t034_early", bus.pkt_vld, 0);
    end
    tick();
    check("t034_early", bus.pkt_vld, 0);
    tick();
    check("t034_vld", bus.pkt_vld, 1);
    check("t034_mshr", bus.pkt_mshr_id, 1);
    check("t034_size", bus.pkt_size, 4);
    check("t034_pl", bus.pkt_payload, 32'h13121110);
    tick();
    check("t034_hs", bus.pkt_vld, 0);
    // interleaved packets with stalled consumer
    bus.pkt_rdy = 1'b0;
    send(0, 1, 2, 0, 'h01);
    send(3, 2, 2, 0, 'h31);
    send(0, 1, 2, 1, 'h02);
    send(3, 2, 2, 1, 'h32);
    wait_vld("t035_vld", 6);
    for (int i = 0; i < 5; i++) begin
      check("t035_hold_id", bus.pkt_mshr_id, 0);
      check("t035_hold_pl", {bus.pkt_vld, bus.pkt_size, bus.pkt_payload}, {1'b1, 3'd2, 32'h0201});
      tick();
    end
    check("t035_held", {bus.pkt_vld, bus.pkt_mshr_id}, {1'b1, 2'd0});
    bus.pkt_rdy = 1'b1;
    tick();
    check("t035_next_id", {bus.pkt_vld, bus.pkt_mshr_id}, {1'b1, 2'd3});
    check("t035_next_pl", {bus.pkt_requester_id, bus.pkt_payload}, {4'd2, 32'h3231});
    tick();
    check("t035_empty", bus.pkt_vld, 0);
    // all four slots done together drain in round-robin order
    bus.pkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(i, 8 + i, 1, 0, 'hC0 + i);
    tick();
    tick();
    tick();
    check("t036_vld", bus.pkt_vld, 1);
    bus.pkt_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t036_id", {bus.pkt_vld, bus.pkt_mshr_id}, {1'b1, 2'(i)});
      check("t036_pl", bus.pkt_payload[7:0], 'hC0 + i);
      tick();
    end
    check("t036_empty", bus.pkt_vld, 0);
    // duplicate flit_id into a collecting slot
    send(1, 3, 3, 0, 'h70);
    send(1, 3, 3, 1, 'h71);
    send(1, 3, 3, 1, 'h7F);
    check("t037_err", bus.err, exp_err);
    send(1, 3, 3, 2, 'h72);
    wait_vld("t037_vld", 6);
    check("t037_pl", bus.pkt_payload[23:0], exp_err ? 24'h727170 : 24'h727F70);
    tick();
    check("t037_err_sticky", {bus.err, bus.pkt_vld}, {exp_err, 1'b0});
    // reset in the middle of a packet discards it
    send(2, 4, 4, 0, 'h40);
    send(2, 4, 4, 1, 'h41);
    reset = 1'b1;
    bus.ej_flit = mk(2, 4, 4, 2, 'h42);
    tick();
    bus.ej_flit = '0;
    reset = 1'b0;
    check("t038_err", bus.err, 0);
    for (int i = 0; i < 6; i++) begin
      check("t038_novld", bus.pkt_vld, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) send(2, 7, 4, i, 'h50 + i);
    wait_vld("t038_vld", 6);
    check("t038_pkt", {bus.pkt_mshr_id, bus.pkt_requester_id, bus.pkt_size, bus.pkt_payload},
          {2'd2, 4'd7, 3'd4, 32'h53525150});
    tick();
    // randomized traffic: every handshaken packet must match its slot's model packet
    for (int i = 0; i < 4; i++) busy[i] = 0;
    started = 0;
    delivered = 0;
    cyc = 0;
    hold_v = 1'b0;
    hold_val = '0;
    free_m = 0;
    while (delivered < NPKT && cyc < 5000) begin
      bus.pkt_rdy = $urandom_range(3) != 0;
      hs = bus.pkt_vld && bus.pkt_rdy;
      cur = {bus.pkt_vld, bus.pkt_mshr_id, bus.pkt_requester_id, bus.pkt_size, bus.pkt_payload};
      if (hold_v) check("rnd_stable", cur, hold_val);
      hold_v = bus.pkt_vld && !bus.pkt_rdy;
      hold_val = cur;
      if (hs) begin
        m = int'(bus.pkt_mshr_id);
        check("rnd_complete", busy[m] != 0 && nxt[m] == sz[m], 1);
        exp_pl = '0;
        msk = '0;
        for (int k = 0; k < 4; k++)
          if (k < sz[m]) begin
            exp_pl[k*8 +: 8] = dat[m][k];
            msk[k*8 +: 8] = 8'hFF;
          end
        check("rnd_pkt", {bus.pkt_requester_id, bus.pkt_size, bus.pkt_payload & msk},
              {4'(rid[m]), 3'(sz[m]), exp_pl});
        free_m = m;
        delivered++;
      end
      chosen = -1;
      if ($urandom_range(3) != 0) begin
        s0 = int'($urandom_range(3));
        for (int k = 0; k < 4; k++) begin
          j = (s0 + k) % 4;
          if (chosen < 0 && ((busy[j] != 0 && nxt[j] < sz[j]) || (busy[j] == 0 && started < NPKT)))
            chosen = j;
        end
      end
      if (chosen >= 0) begin
        j = chosen;
        if (busy[j] == 0) begin
          busy[j] = 1;
          started++;
          sz[j] = int'($urandom_range(4, 1));
          rid[j] = int'($urandom_range(15));
          nxt[j] = 0;
          for (int k = 0; k < 4; k++) begin
            ord[j][k] = k;
            dat[j][k] = 8'($urandom);
          end
          for (int a = sz[j] - 1; a > 0; a--) begin
            b = int'($urandom_range(a));
            t = ord[j][a];
            ord[j][a] = ord[j][b];
            ord[j][b] = t;
          end
        end
        bus.ej_flit = mk(j, rid[j], sz[j], ord[j][nxt[j]], dat[j][ord[j][nxt[j]]]);
        nxt[j]++;
      end else bus.ej_flit = '0;
      tick();
      cyc++;
      if (hs) busy[free_m] = 0;
    end
    bus.ej_flit = '0;
    check("rnd_count", delivered, NPKT);
    check("rnd_err", bus.err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
